// File: rtl/framebuffer_write_arbiter.sv
// framebuffer_write_arbiter
// Owns the framebuffer write port. It shares the port between CPU pixel writes
// and a rectangle-fill engine, and turns scanout (x, y) into a linear read address.
module framebuffer_write_arbiter #(
  parameter int BITS_PER_PIXEL = 3,
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  localparam int ADDR_W = $clog2(FRAME_WIDTH * FRAME_HEIGHT - 1) + 1,
  localparam int XW     = $clog2(FRAME_WIDTH),
  localparam int YW     = $clog2(FRAME_HEIGHT)
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  input  logic                      i_Cpu_Valid,
  output logic                      o_Cpu_Ready,
  input  logic [ADDR_W-1:0]         i_Cpu_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Cpu_Data,
  input  logic                      i_Fill_Start,
  input  logic [XW-1:0]             i_Fill_X0,
  input  logic [XW-1:0]             i_Fill_X1,
  input  logic [YW-1:0]             i_Fill_Y0,
  input  logic [YW-1:0]             i_Fill_Y1,
  input  logic [BITS_PER_PIXEL-1:0] i_Fill_Color,
  output logic                      o_Fill_Busy,
  output logic                      o_Fill_Done,
  input  logic                      i_Scan_Active,
  input  logic [XW-1:0]             i_Scan_X,
  input  logic [YW-1:0]             i_Scan_Y,
  output logic                      o_Write_Enable,
  output logic [ADDR_W-1:0]         o_Write_Addr,
  output logic [BITS_PER_PIXEL-1:0] o_Write_Data,
  output logic [ADDR_W-1:0]         o_Read_Addr
);

  localparam logic [XW-1:0]     X_MAX   = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0]     Y_MAX   = YW'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LINE_SZ = ADDR_W'(FRAME_WIDTH);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                    state, next_state;
  logic                      cpu_hs, fill_grant, fill_last, start_empty, start_ok;
  logic [XW-1:0]             x1_clamped;
  logic [YW-1:0]             y1_clamped;
  logic                      last_grant_cpu;
  logic [XW-1:0]             cur_x, x0_r, x1_r;
  logic [YW-1:0]             cur_y, y1_r;
  logic [ADDR_W-1:0]         cur_addr, row_base;
  logic [BITS_PER_PIXEL-1:0] color_r;

  // Clamp the requested rectangle to the frame and decide whether it is empty
  always_comb begin
    x1_clamped  = (i_Fill_X1 > X_MAX) ? X_MAX : i_Fill_X1;
    y1_clamped  = (i_Fill_Y1 > Y_MAX) ? Y_MAX : i_Fill_Y1;
    start_empty = (i_Fill_X0 > x1_clamped) || (i_Fill_Y0 > y1_clamped);
    start_ok    = (state == IDLE) && i_Fill_Start && !start_empty;
    fill_last   = (cur_x == x1_r) && (cur_y == y1_r);
  end

  // State register
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) state <= IDLE;
    else            state <= next_state;
  end

  // Next state: enter FILL on a non-empty start, leave on the last pixel's grant
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = FILL;
      FILL:    if (fill_grant && fill_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Arbitration: CPU always ready in IDLE, alternates with the fill engine in FILL
  always_comb begin
    o_Cpu_Ready = (state == IDLE) || !last_grant_cpu;
    cpu_hs      = i_Cpu_Valid && o_Cpu_Ready;
    fill_grant  = (state == FILL) && !cpu_hs;
  end

  // Registered write port and fill status flags
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      o_Write_Enable <= 1'b0;
      o_Write_Addr   <= '0;
      o_Write_Data   <= '0;
      o_Fill_Busy    <= 1'b0;
      o_Fill_Done    <= 1'b0;
      last_grant_cpu <= 1'b0;
    end else begin
      o_Write_Enable <= cpu_hs || fill_grant;
      if (cpu_hs) begin
        o_Write_Addr <= i_Cpu_Addr;
        o_Write_Data <= i_Cpu_Data;
      end else if (fill_grant) begin
        o_Write_Addr <= cur_addr;
        o_Write_Data <= color_r;
      end
      if ((state == FILL) && cpu_hs) last_grant_cpu <= 1'b1;
      else if (fill_grant)           last_grant_cpu <= 1'b0;
      o_Fill_Busy <= (next_state == FILL);
      o_Fill_Done <= ((state == IDLE) && i_Fill_Start && start_empty) ||
                     (fill_grant && fill_last);
    end
  end

  // Fill cursor: one multiply at start, then only increments while walking rows
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      cur_x    <= '0;
      cur_y    <= '0;
      x0_r     <= '0;
      x1_r     <= '0;
      y1_r     <= '0;
      color_r  <= '0;
      cur_addr <= '0;
      row_base <= '0;
    end else if (start_ok) begin
      cur_x    <= i_Fill_X0;
      cur_y    <= i_Fill_Y0;
      x0_r     <= i_Fill_X0;
      x1_r     <= x1_clamped;
      y1_r     <= y1_clamped;
      color_r  <= i_Fill_Color;
      row_base <= ADDR_W'(i_Fill_Y0) * LINE_SZ;
      cur_addr <= ADDR_W'(i_Fill_Y0) * LINE_SZ + ADDR_W'(i_Fill_X0);
    end else if (fill_grant && !fill_last) begin
      if (cur_x == x1_r) begin
        cur_x    <= x0_r;
        cur_y    <= cur_y + YW'(1);
        row_base <= row_base + LINE_SZ;
        cur_addr <= row_base + LINE_SZ + ADDR_W'(x0_r);
      end else begin
        cur_x    <= cur_x + XW'(1);
        cur_addr <= cur_addr + ADDR_W'(1);
      end
    end
  end

  // Scanout read address, held while outside the visible region
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N)         o_Read_Addr <= '0;
    else if (i_Scan_Active) o_Read_Addr <= ADDR_W'(i_Scan_Y) * LINE_SZ + ADDR_W'(i_Scan_X);
  end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Testbench for framebuffer_write_arbiter: directed steps with a write scoreboard
module tb_framebuffer_write_arbiter;

  localparam int W = 640;
  localparam int H = 480;

  logic        clock = 1'b0;
  logic        resetN;
  logic        cpuValid;
  logic        cpuReady;
  logic [19:0] cpuAddr;
  logic [2:0]  cpuData;
  logic        fillStart;
  logic [9:0]  fillX0, fillX1;
  logic [8:0]  fillY0, fillY1;
  logic [2:0]  fillColor;
  logic        fillBusy, fillDone;
  logic        scanActive;
  logic [9:0]  scanX;
  logic [8:0]  scanY;
  logic        writeEnable;
  logic [19:0] writeAddr;
  logic [2:0]  writeData;
  logic [19:0] readAddr;

  typedef struct {
    logic [19:0] addr;
    logic [2:0]  data;
  } wr_t;

  wr_t scoreboard[$];
  int  testCount = 0;
  int  failCount = 0;

  framebuffer_write_arbiter dut (
    .i_Clock       (clock),
    .i_Reset_N     (resetN),
    .i_Cpu_Valid   (cpuValid),
    .o_Cpu_Ready   (cpuReady),
    .i_Cpu_Addr    (cpuAddr),
    .i_Cpu_Data    (cpuData),
    .i_Fill_Start  (fillStart),
    .i_Fill_X0     (fillX0),
    .i_Fill_X1     (fillX1),
    .i_Fill_Y0     (fillY0),
    .i_Fill_Y1     (fillY1),
    .i_Fill_Color  (fillColor),
    .o_Fill_Busy   (fillBusy),
    .o_Fill_Done   (fillDone),
    .i_Scan_Active (scanActive),
    .i_Scan_X      (scanX),
    .i_Scan_Y      (scanY),
    .o_Write_Enable(writeEnable),
    .o_Write_Addr  (writeAddr),
    .o_Write_Data  (writeData),
    .o_Read_Addr   (readAddr)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [19:0] addr, input logic [2:0] data);
    cpuValid = valid;
    cpuAddr  = addr;
    cpuData  = data;
  endtask

  // Advance one cycle; outputs are then stable from the edge just taken
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushWrite(input int addr, input int data);
    wr_t e;
    e.addr = 20'(addr);
    e.data = 3'(data);
    scoreboard.push_back(e);
  endtask

  // Reference model of a fill: clamp, then raster order; returns pixel count
  task automatic pushFill(input int x0, input int x1, input int y0, input int y1,
                          input int color, output int count);
    int cx1, cy1;
    cx1   = (x1 > W - 1) ? W - 1 : x1;
    cy1   = (y1 > H - 1) ? H - 1 : y1;
    count = 0;
    for (int y = y0; y <= cy1; y++)
      for (int x = x0; x <= cx1; x++) begin
        pushWrite(y * W + x, color);
        count++;
      end
  endtask

  task automatic setFill(input int x0, input int x1, input int y0, input int y1, input int color);
    fillX0    = 10'(x0);
    fillX1    = 10'(x1);
    fillY0    = 9'(y0);
    fillY1    = 9'(y1);
    fillColor = 3'(color);
  endtask

  // Uncontested fill: every pixel on consecutive cycles, optional ignored restart
  task automatic runFill(input int x0, input int x1, input int y0, input int y1,
                         input int color, input bit pokeStart);
    int n;
    pushFill(x0, x1, y0, y1, color, n);
    setFill(x0, x1, y0, y1, color);
    fillStart = 1'b1;
    tick();
    fillStart = 1'b0;
    checkOutput("fill_busy_start", 32'(fillBusy), 1);
    checkOutput("fill_we_start", 32'(writeEnable), 0);
    for (int i = 0; i < n; i++) begin
      if (pokeStart && i == 0) begin
        fillStart = 1'b1;
        setFill(0, 0, 0, 0, 1);
      end else begin
        fillStart = 1'b0;
      end
      tick();
      checkOutput("fill_we", 32'(writeEnable), 1);
      checkOutput("fill_done", 32'(fillDone), (i == n - 1) ? 1 : 0);
      checkOutput("fill_busy", 32'(fillBusy), (i == n - 1) ? 0 : 1);
    end
    fillStart = 1'b0;
    tick();
    checkOutput("fill_we_after", 32'(writeEnable), 0);
    checkOutput("fill_done_after", 32'(fillDone), 0);
  endtask

  // Every write leaving the DUT must match the oldest expected write
  always @(negedge clock) begin
    if (writeEnable) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_write", 32'(writeAddr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = scoreboard.pop_front();
        checkOutput("write_addr", 32'(writeAddr), 32'(e.addr));
        checkOutput("write_data", 32'(writeData), 32'(e.data));
      end
    end
  end

  initial begin
    int n;
    resetN     = 1'b0;
    fillStart  = 1'b0;
    scanActive = 1'b0;
    scanX      = '0;
    scanY      = '0;
    setFill(0, 0, 0, 0, 0);
    applyStimulus(1'b0, '0, '0);
    tick();
    tick();
    checkOutput("rst_we", 32'(writeEnable), 0);
    checkOutput("rst_waddr", 32'(writeAddr), 0);
    checkOutput("rst_wdata", 32'(writeData), 0);
    checkOutput("rst_raddr", 32'(readAddr), 0);
    checkOutput("rst_busy", 32'(fillBusy), 0);
    checkOutput("rst_done", 32'(fillDone), 0);
    checkOutput("rst_ready", 32'(cpuReady), 1);
    resetN = 1'b1;
    tick();

    $display("[TB] CPU write in IDLE");
    applyStimulus(1'b1, 20'd1234, 3'd5);
    checkOutput("cpu_ready_idle", 32'(cpuReady), 1);
    pushWrite(1234, 5);
    tick();
    checkOutput("cpu_we", 32'(writeEnable), 1);
    applyStimulus(1'b0, '0, '0);
    tick();
    checkOutput("cpu_we_off", 32'(writeEnable), 0);
    checkOutput("cpu_addr_hold", 32'(writeAddr), 1234);

    $display("[TB] uncontested 2x2 fill");
    runFill(1, 2, 1, 2, 7, 1'b0);

    $display("[TB] contested fill");
    n = 0;
    pushWrite(0, 2); pushWrite(641, 7); pushWrite(0, 2); pushWrite(642, 7);
    pushWrite(0, 2); pushWrite(1281, 7); pushWrite(0, 2); pushWrite(1282, 7);
    pushWrite(0, 2); pushWrite(0, 2);
    setFill(1, 2, 1, 2, 7);
    fillStart = 1'b1;
    tick();
    fillStart = 1'b0;
    applyStimulus(1'b1, 20'd0, 3'd2);
    checkOutput("cont_busy", 32'(fillBusy), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 9) applyStimulus(1'b0, '0, '0);
      checkOutput("cont_we", 32'(writeEnable), 1);
      checkOutput("cont_done", 32'(fillDone), (i == 7) ? 1 : 0);
      checkOutput("cont_ready", 32'(cpuReady), ((i % 2 == 1) || i >= 7) ? 1 : 0);
    end
    tick();
    checkOutput("cont_we_after", 32'(writeEnable), 0);

    $display("[TB] empty fill");
    setFill(5, 3, 0, 0, 4);
    fillStart = 1'b1;
    tick();
    fillStart = 1'b0;
    checkOutput("empty_done", 32'(fillDone), 1);
    checkOutput("empty_busy", 32'(fillBusy), 0);
    checkOutput("empty_we", 32'(writeEnable), 0);
    tick();
    checkOutput("empty_done_off", 32'(fillDone), 0);
    checkOutput("empty_we_off", 32'(writeEnable), 0);

    $display("[TB] clamped fill with ignored restart");
    runFill(638, 900, 478, 511, 6, 1'b1);

    $display("[TB] scanout");
    scanActive = 1'b1;
    scanX      = 10'd639;
    scanY      = 9'd479;
    tick();
    checkOutput("scan_addr", 32'(readAddr), 307199);
    scanActive = 1'b0;
    scanX      = 10'd1;
    scanY      = 9'd1;
    tick();
    checkOutput("scan_hold", 32'(readAddr), 307199);
    scanActive = 1'b1;
    scanX      = 10'd3;
    scanY      = 9'd2;
    tick();
    scanActive = 1'b0;
    checkOutput("scan_addr2", 32'(readAddr), 1283);

    $display("[TB] reset mid-fill");
    pushWrite(0, 3);
    pushWrite(1, 3);
    setFill(0, 9, 0, 9, 3);
    fillStart = 1'b1;
    tick();
    fillStart = 1'b0;
    tick();
    checkOutput("abort_we1", 32'(writeEnable), 1);
    tick();
    checkOutput("abort_we2", 32'(writeEnable), 1);
    resetN = 1'b0;
    tick();
    checkOutput("abort_we", 32'(writeEnable), 0);
    checkOutput("abort_waddr", 32'(writeAddr), 0);
    checkOutput("abort_wdata", 32'(writeData), 0);
    checkOutput("abort_raddr", 32'(readAddr), 0);
    checkOutput("abort_busy", 32'(fillBusy), 0);
    checkOutput("abort_done", 32'(fillDone), 0);
    checkOutput("abort_ready", 32'(cpuReady), 1);
    resetN = 1'b1;
    tick();
    tick();
    checkOutput("post_reset_we", 32'(writeEnable), 0);
    checkOutput("post_reset_done", 32'(fillDone), 0);
    checkOutput("post_reset_busy", 32'(fillBusy), 0);
    checkOutput("scoreboard_empty", 32'(scoreboard.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
